// File: rtl/vend_controller.sv
// Vending sequencer: nickel-unit credit, purchase/dispense, then change or refund paid as a nickel pulse train.
// Latency: every output is registered and responds one cycle after its input pulse; inputs are pulses with no backpressure.
module vend_controller #(
    parameter int CREDIT_W   = 6,
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 20
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                nickel_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                sel_i,
    input  logic                cancel_i,
    output logic                dispense_o,
    output logic                change_o,
    output logic                coin_reject_o,
    output logic                insufficient_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, GAP} state_t;

    state_t                state, state_nxt;
    logic [CREDIT_W-1:0]   credit_nxt;
    logic                  dispense_nxt, change_nxt, reject_nxt, insuff_nxt;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W:0]     coin_sum;
    logic                  any_coin, multi_coin;

    // Only the highest-value coin counts; the sum is one bit wider so it cannot wrap.
    always_comb begin
        if (quarter_i)
            coin_val = CREDIT_W'(5);
        else if (dime_i)
            coin_val = CREDIT_W'(2);
        else if (nickel_i)
            coin_val = CREDIT_W'(1);
        else
            coin_val = '0;
        any_coin   = nickel_i | dime_i | quarter_i;
        multi_coin = (nickel_i & dime_i) | (nickel_i & quarter_i) | (dime_i & quarter_i);
        coin_sum   = {1'b0, credit_o} + {1'b0, coin_val};
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit_o;
        dispense_nxt = 1'b0;
        change_nxt   = 1'b0;
        reject_nxt   = 1'b0;
        insuff_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cancel_i) begin
                    reject_nxt = any_coin;
                    if (credit_o != '0)
                        state_nxt = CHANGE;
                end else if (sel_i) begin
                    reject_nxt = any_coin;
                    if (credit_o >= PRICE_C) begin
                        dispense_nxt = 1'b1;
                        credit_nxt   = credit_o - PRICE_C;
                        state_nxt    = DISPENSE;
                    end else begin
                        insuff_nxt = 1'b1;
                    end
                end else if (any_coin) begin
                    if (coin_sum <= MAX_C) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        reject_nxt = multi_coin;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            CHANGE: begin
                reject_nxt = any_coin;
                change_nxt = 1'b1;
                credit_nxt = credit_o - ONE_C;
                state_nxt  = GAP;
            end
            DISPENSE, GAP: begin
                reject_nxt = any_coin;
                state_nxt  = (credit_o != '0) ? CHANGE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            credit_o       <= '0;
            dispense_o     <= 1'b0;
            change_o       <= 1'b0;
            coin_reject_o  <= 1'b0;
            insufficient_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            credit_o       <= credit_nxt;
            dispense_o     <= dispense_nxt;
            change_o       <= change_nxt;
            coin_reject_o  <= reject_nxt;
            insufficient_o <= insuff_nxt;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed pulse sequences, an arithmetic payout-schedule model checked every cycle,
// plus literal expectations on key points of each scenario.
module tb_vend_controller;

    localparam int CW    = 6;
    localparam int PRICE = 15;
    localparam int MAXC  = 20;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          nickel_i = 1'b0, dime_i = 1'b0, quarter_i = 1'b0, sel_i = 1'b0, cancel_i = 1'b0;
    logic          dispense_o, change_o, coin_reject_o, insufficient_o, busy_o;
    logic [CW-1:0] credit_o;

    vend_controller #(.CREDIT_W(CW), .PRICE(PRICE), .MAX_CREDIT(MAXC)) dut (
        .Clk(Clk), .Rst(Rst),
        .nickel_i(nickel_i), .dime_i(dime_i), .quarter_i(quarter_i),
        .sel_i(sel_i), .cancel_i(cancel_i),
        .dispense_o(dispense_o), .change_o(change_o), .coin_reject_o(coin_reject_o),
        .insufficient_o(insufficient_o), .credit_o(credit_o), .busy_o(busy_o)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a purchase or cancel fixes a payout schedule (first change edge, nickel count, last busy edge);
    // outputs after any edge follow from that schedule by arithmetic on the edge index.
    int e = 0, mc = 0, b = -10, pay_n = 0, pay_start = 0, disp_edge = -10;
    int ncoin, val, done;
    int exp_credit = 0;
    bit exp_disp, exp_chg, exp_rej, exp_ins, exp_busy;
    bit model_valid = 1'b0;

    always @(posedge Clk) begin
        e++;
        exp_rej = 1'b0;
        exp_ins = 1'b0;
        ncoin = int'(nickel_i) + int'(dime_i) + int'(quarter_i);
        val = quarter_i ? 5 : dime_i ? 2 : nickel_i ? 1 : 0;
        if (Rst) begin
            mc = 0; b = -10; pay_n = 0; pay_start = 0; disp_edge = -10;
        end else if (e - 1 > b) begin
            if (cancel_i) begin
                exp_rej = (ncoin > 0);
                if (mc > 0) begin
                    pay_start = e + 1; pay_n = mc; b = e + 2 * mc - 1; mc = 0;
                end
            end else if (sel_i && mc >= PRICE) begin
                exp_rej = (ncoin > 0);
                disp_edge = e; pay_n = mc - PRICE; pay_start = e + 2; b = e + 2 * pay_n; mc = 0;
            end else if (sel_i) begin
                exp_ins = 1'b1;
                exp_rej = (ncoin > 0);
            end else if (ncoin > 0) begin
                exp_rej = (ncoin > 1) || (mc + val > MAXC);
                if (mc + val <= MAXC) mc = mc + val;
            end
        end else begin
            exp_rej = (ncoin > 0);
        end
        if (e <= b) begin
            done = (e >= pay_start) ? (e - pay_start) / 2 + 1 : 0;
            if (done > pay_n) done = pay_n;
            exp_credit = pay_n - done;
            exp_chg = (e >= pay_start) && ((e - pay_start) % 2 == 0) && ((e - pay_start) / 2 < pay_n);
            exp_busy = 1'b1;
        end else begin
            exp_credit = mc;
            exp_chg = 1'b0;
            exp_busy = 1'b0;
        end
        exp_disp = (e == disp_edge);
        model_valid = 1'b1;
    end

    always @(negedge Clk) begin
        if (model_valid) begin
            chk("cyc dispense_o", int'(dispense_o), int'(exp_disp));
            chk("cyc change_o", int'(change_o), int'(exp_chg));
            chk("cyc coin_reject_o", int'(coin_reject_o), int'(exp_rej));
            chk("cyc insufficient_o", int'(insufficient_o), int'(exp_ins));
            chk("cyc credit_o", int'(credit_o), exp_credit);
            chk("cyc busy_o", int'(busy_o), int'(exp_busy));
        end
    end

    int chg_seen = 0;
    int disp_seen = 0;

    task automatic step();
        @(negedge Clk);
        if (change_o) chg_seen++;
        if (dispense_o) disp_seen++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic pulse(input bit n, input bit d, input bit q, input bit s, input bit c);
        nickel_i = n; dime_i = d; quarter_i = q; sel_i = s; cancel_i = c;
        step();
        nickel_i = 0; dime_i = 0; quarter_i = 0; sel_i = 0; cancel_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        steps(2);
        Rst = 1'b0;
        chk("reset credit", int'(credit_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset dispense", int'(dispense_o), 0);

        // exact price: three quarters then select
        pulse(0, 0, 1, 0, 0); chk("q1 credit", int'(credit_o), 5);
        pulse(0, 0, 1, 0, 0); chk("q2 credit", int'(credit_o), 10);
        pulse(0, 0, 1, 0, 0); chk("q3 credit", int'(credit_o), 15);
        chg_seen = 0; disp_seen = 0;
        pulse(0, 0, 0, 1, 0);
        chk("buy15 dispense", int'(dispense_o), 1);
        chk("buy15 credit", int'(credit_o), 0);
        steps(3);
        chk("buy15 idle", int'(busy_o), 0);
        chk("buy15 no change", chg_seen, 0);
        chk("buy15 one dispense", disp_seen, 1);

        // purchase with five nickels of change
        repeat (4) pulse(0, 0, 1, 0, 0);
        chk("4q credit", int'(credit_o), 20);
        chg_seen = 0; disp_seen = 0;
        pulse(0, 0, 0, 1, 0);
        chk("buy20 credit", int'(credit_o), 5);
        step();
        chk("buy20 dispense gone", int'(dispense_o), 0);
        step();
        chk("buy20 first change", int'(change_o), 1);
        chk("buy20 credit4", int'(credit_o), 4);
        steps(10);
        chk("buy20 change count", chg_seen, 5);
        chk("buy20 dispense count", disp_seen, 1);
        chk("buy20 idle", int'(busy_o), 0);

        // cancel refund
        pulse(0, 0, 1, 0, 0);
        pulse(0, 1, 0, 0, 0);
        chk("qd credit", int'(credit_o), 7);
        chg_seen = 0; disp_seen = 0;
        pulse(0, 0, 0, 0, 1);
        chk("cancel busy", int'(busy_o), 1);
        steps(16);
        chk("cancel change count", chg_seen, 7);
        chk("cancel no dispense", disp_seen, 0);
        pulse(0, 0, 0, 0, 1);
        chk("cancel0 busy", int'(busy_o), 0);
        chk("cancel0 credit", int'(credit_o), 0);

        // ceiling and coins during payout
        repeat (3) pulse(0, 0, 1, 0, 0);
        repeat (2) pulse(0, 1, 0, 0, 0);
        chk("credit19", int'(credit_o), 19);
        pulse(0, 1, 0, 0, 0);
        chk("overflow reject", int'(coin_reject_o), 1);
        chk("overflow credit", int'(credit_o), 19);
        pulse(1, 0, 0, 0, 0);
        chk("nickel to 20", int'(credit_o), 20);
        chk("nickel accepted", int'(coin_reject_o), 0);
        chg_seen = 0;
        pulse(0, 0, 0, 1, 0);
        step();
        pulse(1, 0, 0, 0, 0);
        chk("busy coin reject", int'(coin_reject_o), 1);
        steps(12);
        chk("busy coin change count", chg_seen, 5);
        chk("busy coin credit", int'(credit_o), 0);

        // insufficient credit and simultaneous inputs
        repeat (2) pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 1, 0);
        chk("insuff pulse", int'(insufficient_o), 1);
        chk("insuff credit", int'(credit_o), 10);
        pulse(0, 0, 1, 1, 0);
        chk("sel+q insuff", int'(insufficient_o), 1);
        chk("sel+q reject", int'(coin_reject_o), 1);
        chk("sel+q credit", int'(credit_o), 10);
        pulse(1, 0, 1, 0, 0);
        chk("q+n credit", int'(credit_o), 15);
        chk("q+n reject", int'(coin_reject_o), 1);
        pulse(0, 0, 0, 0, 1);
        steps(32);
        chk("drain idle", int'(busy_o), 0);

        // reset in the middle of a payout
        repeat (4) pulse(0, 0, 1, 0, 0);
        chg_seen = 0;
        pulse(0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && chg_seen < 2; i++) step();
        chk("rst two changes seen", chg_seen, 2);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("rst credit", int'(credit_o), 0);
        chk("rst busy", int'(busy_o), 0);
        chk("rst change", int'(change_o), 0);
        chg_seen = 0;
        steps(10);
        chk("rst no more change", chg_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
